arm_multicycle_ctrl: RTL and testbench
======================================

# arm_multicycle_ctrl

Multicycle control unit for the ARM-subset processor core. It sequences the shared datapath: the single memory port, register file, immediate extender and ALU. It does this with a Moore state machine that fetches, decodes and executes one instruction over 3–5 cycles. It holds the architectural NZCV flag register and evaluates ARM condition codes. A stall input lets the keyboard-driven program loader freeze the core while it owns the memory port.

## Interface
No parameters.

Ports:
- CLK  in  1  system clock; all state changes on rising edge
- RST  in  1  synchronous, active-high reset
- Stall  in  1  loader owns memory; FSM holds, all enables forced 0
- Instr  in  32  instruction register contents (valid from DECODE on)
- ALU_Flags  in  4  live ALU flags, [3]=N [2]=Z [1]=C [0]=V
- PCWrite  out  1  PC register load enable
- IRWrite  out  1  instruction register load enable
- MemWrite  out  1  data write strobe
- RegWrite  out  1  register file write enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- ALUSrcA  out  1  0=RD1, 1=PC
- ALUSrcB  out  2  00=RD2, 01=extended imm, 10=constant 4
- ResultSrc  out  2  00=ALUOut reg, 01=read data reg, 10=ALU direct
- ALU_Code  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- ImmSrc  out  2  Instr[27:26] (00 DP imm8, 01 mem imm12, 10 branch imm24)
- RegSrc  out  2  [0]=1 when op=10 (read R15), [1]=1 when op=01 (read Rd for STR)
- Flags  out  4  architectural NZCV register
- State  out  4  current state encoding (debug)

## Operation
- Decode fields: cond=Instr[31:28], op=Instr[27:26], funct=Instr[25:20], Rd=Instr[15:12].
- States and encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4
  - MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9
- Transitions:
  - FETCH→DECODE.
  - DECODE→FETCH if the condition fails or op=11. Otherwise op=01→MEMADR, op=10→BRANCH, op=00 with funct[5]=1→EXECI, op=00 with funct[5]=0→EXECR.
  - MEMADR→MEMRD if funct[0]=1 (LDR), else MEMWR.
  - MEMRD→MEMWB.
  - EXECR/EXECI→ALUWB.
  - MEMWB, MEMWR, ALUWB and BRANCH→FETCH.
  - Encodings 10–15 are illegal and go to FETCH.
- Outputs per state (all unlisted enables 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01. ALU_Code is ADD if funct[3]=1 (U), else SUB.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1. If Rd=15, PCWrite=1.
  - MEMWR: AdrSrc=1, MemWrite=1.
  - EXECR: ALUSrcA=0, ALUSrcB=00, ALU_Code from cmd.
  - EXECI: ALUSrcA=0, ALUSrcB=01, ALU_Code from cmd.
  - ALUWB: ResultSrc=00. RegWrite=1 unless cmd=CMP. PCWrite=1 if Rd=15 and not CMP.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=1. BL is executed as B; no link.
- cmd=funct[4:1] mapping:
  - 0100 → ADD
  - 0010 → SUB
  - 0000 → AND
  - 1100 → ORR
  - 1010 → CMP (SUB, S forced to 1)
  - Any other value → ADD.
- Flags: loaded from ALU_Flags at the end of EXECR/EXECI when funct[0]=1 or cmd=CMP. No other state writes Flags.
- Condition check uses the registered Flags as of DECODE. It covers EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE and AL; cond=1111 fails.

## Timing
- Latencies:
  - DP: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - Branch: 3 cycles.
  - Condition-failed or undefined: 2 cycles.
- Control outputs are combinational from State and Instr only (Moore plus field decode). There is no combinational path from ALU_Flags to any output.
- Reset: while RST=1, State and Flags are 0 on the next edge and all enables (PCWrite, IRWrite, MemWrite, RegWrite) are forced 0. Mux selects show their FETCH values. The first fetch happens in the first cycle with RST=0.
- Reset mid-instruction aborts the instruction; no partial writes after the reset edge.
- Stall=1: State and Flags hold and all enables are forced 0. Mux selects keep their state values. On release, the held state resumes with full outputs.
- RST and Stall both high: reset wins.

## Configuration
- COND_EXEC_EN defined: condition check enabled as described.
- COND_EXEC_EN undefined: every cond is treated as AL. The DECODE→FETCH skip occurs only for op=11. Flags register and updates remain.

## Test plan
- Reset, then 0xE2810005 (ADD R0,R1,#5):
  - State sequence 0,1,7,8,0.
  - RegWrite=1 only in ALUWB.
  - ImmSrc=00, ALU_Code=00.
- 0xE5910004 (LDR R1,[R1,#4]), then 0xE5810004 (STR):
  - LDR runs 5 cycles; RegWrite=1 with ResultSrc=01 in MEMWB.
  - STR runs 4 cycles; MemWrite=1 and AdrSrc=1 only in MEMWR; RegSrc=10.
- 0xE3510000 (CMP R1,#0) with ALU_Flags=0100 in EXECI:
  - Flags=0100 after EXECI.
  - No RegWrite in ALUWB.
  - Next 0x0A000001 (BEQ) takes 3 cycles with PCWrite=1 in BRANCH.
- Flags=0000 and 0x0A000001 (BEQ):
  - States 0,1,0; no enables in DECODE.
  - With COND_EXEC_EN undefined, the branch is taken instead.
- Stall raised for 3 cycles in MEMADR:
  - State holds at 2 with all enables 0.
  - Completes normally after release.
- RST asserted in MEMWR during STR:
  - MemWrite=0 from the reset cycle.
  - State=0 and Flags=0 on the next edge.

Source files
------------

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle Moore controller for the ARM-subset core: FETCH/DECODE/execute sequencing plus NZCV flags.
// Optional build macro COND_EXEC_EN enables ARM condition-code checking; without it every cond acts as AL.
module arm_multicycle_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Stall,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALU_Flags,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALU_Code,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [3:0]  Flags,
    output logic [3:0]  State
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXECR  = 4'd6;
    localparam logic [3:0] EXECI  = 4'd7;
    localparam logic [3:0] ALUWB  = 4'd8;
    localparam logic [3:0] BRANCH = 4'd9;

    logic [3:0] state;
    logic [3:0] next_state;

    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic       rd_is_pc;
    logic [1:0] cmd_alu;
    logic       is_cmp;
    logic       cond_pass;

    logic pc_w;
    logic ir_w;
    logic mem_w;
    logic reg_w;
    logic enable_ok;

    assign op       = Instr[27:26];
    assign funct    = Instr[25:20];
    assign cmd      = funct[4:1];
    assign rd_is_pc = (Instr[15:12] == 4'hF);
    assign is_cmp   = (cmd == 4'b1010);

    always_comb begin
        cmd_alu = 2'b00;
        case (cmd)
            4'b0100: cmd_alu = 2'b00;
            4'b0010: cmd_alu = 2'b01;
            4'b0000: cmd_alu = 2'b10;
            4'b1100: cmd_alu = 2'b11;
            4'b1010: cmd_alu = 2'b01;
            default: cmd_alu = 2'b00;
        endcase
    end

`ifdef COND_EXEC_EN
    logic       unused_instr;
    logic       f_n, f_z, f_c, f_v;
    assign {f_n, f_z, f_c, f_v} = Flags;
    assign unused_instr = ^{Instr[19:16], Instr[11:0]};

    always_comb begin
        cond_pass = 1'b0;
        case (Instr[31:28])
            4'h0: cond_pass = f_z;
            4'h1: cond_pass = !f_z;
            4'h2: cond_pass = f_c;
            4'h3: cond_pass = !f_c;
            4'h4: cond_pass = f_n;
            4'h5: cond_pass = !f_n;
            4'h6: cond_pass = f_v;
            4'h7: cond_pass = !f_v;
            4'h8: cond_pass = f_c && !f_z;
            4'h9: cond_pass = !f_c || f_z;
            4'hA: cond_pass = (f_n == f_v);
            4'hB: cond_pass = (f_n != f_v);
            4'hC: cond_pass = !f_z && (f_n == f_v);
            4'hD: cond_pass = f_z || (f_n != f_v);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end
`else
    logic unused_instr;
    assign unused_instr = ^{Instr[31:28], Instr[19:16], Instr[11:0]};
    assign cond_pass    = 1'b1;
`endif

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                if (!cond_pass || op == 2'b11)
                    next_state = FETCH;
                else if (op == 2'b01)
                    next_state = MEMADR;
                else if (op == 2'b10)
                    next_state = BRANCH;
                else
                    next_state = funct[5] ? EXECI : EXECR;
            end
            MEMADR: next_state = funct[0] ? MEMRD : MEMWR;
            MEMRD:  next_state = MEMWB;
            EXECR,
            EXECI:  next_state = ALUWB;
            default: next_state = FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= FETCH;
            Flags <= '0;
        end else if (!Stall) begin
            state <= next_state;
            if ((state == EXECR || state == EXECI) && (funct[0] || is_cmp))
                Flags <= ALU_Flags;
        end
    end

    always_comb begin
        pc_w      = 1'b0;
        ir_w      = 1'b0;
        mem_w     = 1'b0;
        reg_w     = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALU_Code  = 2'b00;
        case (state)
            FETCH: begin
                ir_w      = 1'b1;
                pc_w      = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: begin
                ALUSrcB  = 2'b01;
                ALU_Code = funct[3] ? 2'b00 : 2'b01;
            end
            MEMRD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
                pc_w      = rd_is_pc;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            EXECR: ALU_Code = cmd_alu;
            EXECI: begin
                ALUSrcB  = 2'b01;
                ALU_Code = cmd_alu;
            end
            ALUWB: begin
                reg_w = !is_cmp;
                pc_w  = rd_is_pc && !is_cmp;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pc_w      = 1'b1;
            end
            default: ;
        endcase
        // During reset the selects already present the FETCH datapath setup.
        if (RST) begin
            AdrSrc    = 1'b0;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            ALU_Code  = 2'b00;
        end
    end

    assign enable_ok = !(RST || Stall);
    assign PCWrite   = pc_w  && enable_ok;
    assign IRWrite   = ir_w  && enable_ok;
    assign MemWrite  = mem_w && enable_ok;
    assign RegWrite  = reg_w && enable_ok;

    assign ImmSrc = op;
    assign RegSrc = {op == 2'b01, op == 2'b10};
    assign State  = state;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Randomized bench for arm_multicycle_ctrl against a per-instruction step-plan model.
// Honors COND_EXEC_EN the same way the design does when the macro is defined for both.
module tb_arm_multicycle_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Stall;
    logic [31:0] Instr;
    logic [3:0]  ALU_Flags;
    logic        PCWrite, IRWrite, MemWrite, RegWrite;
    logic        AdrSrc, ALUSrcA;
    logic [1:0]  ALUSrcB, ResultSrc, ALU_Code, ImmSrc, RegSrc;
    logic [3:0]  Flags, State;

    arm_multicycle_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .Stall     (Stall),
        .Instr     (Instr),
        .ALU_Flags (ALU_Flags),
        .PCWrite   (PCWrite),
        .IRWrite   (IRWrite),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ALU_Code  (ALU_Code),
        .ImmSrc    (ImmSrc),
        .RegSrc    (RegSrc),
        .Flags     (Flags),
        .State     (State)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    logic [3:0] model_flags;
    int plan_q[$];

    // en = {PCWrite, IRWrite, MemWrite, RegWrite}; care = {alu, res, srcb, srca, adr}
    typedef struct packed {
        logic [3:0] en;
        logic       adr;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic [1:0] alu;
        logic [4:0] care;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] alu_of_cmd(input logic [3:0] cmd);
        case (cmd)
            4'b0010, 4'b1010: return 2'b01;
            4'b0000:          return 2'b10;
            4'b1100:          return 2'b11;
            default:          return 2'b00;
        endcase
    endfunction

    // Sequence of states an instruction visits, from the instruction class alone.
    task automatic build_plan(input logic [31:0] ins);
        bit pass;
`ifdef COND_EXEC_EN
        pass = cond_ok(ins[31:28], model_flags);
`else
        pass = 1'b1;
`endif
        plan_q.delete();
        plan_q.push_back(0);
        plan_q.push_back(1);
        if (!pass || ins[27:26] == 2'b11) return;
        case (ins[27:26])
            2'b01: begin
                plan_q.push_back(2);
                if (ins[20]) begin plan_q.push_back(3); plan_q.push_back(4); end
                else plan_q.push_back(5);
            end
            2'b10: plan_q.push_back(9);
            default: begin
                plan_q.push_back(ins[25] ? 7 : 6);
                plan_q.push_back(8);
            end
        endcase
    endtask

    function automatic exp_t expect_for(input int st, input logic [31:0] ins);
        exp_t e;
        logic rd15, cmp;
        rd15 = (ins[15:12] == 4'hF);
        cmp  = (ins[24:21] == 4'b1010);
        e = '0;
        case (st)
            0: begin e.en = 4'b1100; e.srca = 1; e.srcb = 2; e.res = 2; e.care = 5'b11111; end
            1: begin e.srca = 1; e.srcb = 2; e.res = 2; e.care = 5'b11110; end
            2: begin e.srcb = 1; e.alu = ins[23] ? 2'b00 : 2'b01; e.care = 5'b10110; end
            3: begin e.adr = 1; e.care = 5'b01001; end
            4: begin e.en = {rd15, 3'b001}; e.res = 1; e.care = 5'b01000; end
            5: begin e.en = 4'b0010; e.adr = 1; e.care = 5'b00001; end
            6: begin e.alu = alu_of_cmd(ins[24:21]); e.care = 5'b10110; end
            7: begin e.srcb = 1; e.alu = alu_of_cmd(ins[24:21]); e.care = 5'b10110; end
            8: begin e.en = {rd15 && !cmp, 2'b00, !cmp}; e.care = 5'b01000; end
            9: begin e.en = 4'b1000; e.srcb = 1; e.res = 2; e.care = 5'b11110; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check_cycle(input int st, input logic [31:0] ins, input bit held);
        exp_t e;
        e = expect_for(st, ins);
        check("state", State, st);
        check("enables", {PCWrite, IRWrite, MemWrite, RegWrite}, held ? 4'b0000 : e.en);
        if (e.care[0]) check("adrsrc", AdrSrc, e.adr);
        if (e.care[1]) check("alusrca", ALUSrcA, e.srca);
        if (e.care[2]) check("alusrcb", ALUSrcB, e.srcb);
        if (e.care[3]) check("resultsrc", ResultSrc, e.res);
        if (e.care[4]) check("alu_code", ALU_Code, e.alu);
        check("immsrc", ImmSrc, ins[27:26]);
        check("regsrc", RegSrc, {ins[27:26] == 2'b01, ins[27:26] == 2'b10});
        check("flags", Flags, model_flags);
    endtask

    // Entered just after a falling edge; leaves just after a falling edge.
    task automatic run_instr(input logic [31:0] ins, input bit fix_af, input logic [3:0] af,
                             input int stall_at, input int stall_len, input int rst_at);
        int st;
        Instr = ins;
        build_plan(ins);
        for (int i = 0; i < plan_q.size(); i++) begin
            st = plan_q[i];
            if (i == rst_at) begin
                RST = 1'b1;
                Stall = 1'($urandom_range(0, 1));
                ALU_Flags = 4'($urandom);
                #1;
                check("rst_enables", {PCWrite, IRWrite, MemWrite, RegWrite}, 4'b0000);
                check("rst_selects", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALU_Code},
                      {1'b0, 1'b1, 2'b10, 2'b10, 2'b00});
                @(posedge CLK);
                model_flags = '0;
                @(negedge CLK);
                RST = 1'b0;
                Stall = 1'b0;
                #1;
                check("rst_state", State, 0);
                check("rst_flags", Flags, model_flags);
                return;
            end
            if (i == stall_at) begin
                for (int k = 0; k < stall_len; k++) begin
                    Stall = 1'b1;
                    ALU_Flags = 4'($urandom);
                    #1;
                    check_cycle(st, ins, 1'b1);
                    @(posedge CLK);
                    @(negedge CLK);
                end
            end
            Stall = 1'b0;
            ALU_Flags = fix_af ? af : 4'($urandom);
            #1;
            check_cycle(st, ins, 1'b0);
            @(posedge CLK);
            if ((st == 6 || st == 7) && (ins[20] || ins[24:21] == 4'b1010))
                model_flags = ALU_Flags;
            @(negedge CLK);
        end
    endtask

    initial begin
        logic [31:0] ins;
        int s_at, s_len, r_at;
        RST = 1'b1;
        Stall = 1'b0;
        Instr = '0;
        ALU_Flags = '0;
        model_flags = '0;
        @(negedge CLK);
        #1;
        check("init_state", State, 0);
        check("init_flags", Flags, 0);
        check("init_enables", {PCWrite, IRWrite, MemWrite, RegWrite}, 4'b0000);
        @(negedge CLK);
        RST = 1'b0;

        run_instr(32'hE2810005, 1'b0, 4'h0, -1, 0, -1);
        run_instr(32'hE5910004, 1'b0, 4'h0, -1, 0, -1);
        run_instr(32'hE5810004, 1'b0, 4'h0, -1, 0, -1);
        run_instr(32'hE3510000, 1'b1, 4'b0100, -1, 0, -1);
        check("cmp_flags", Flags, 4'b0100);
        run_instr(32'h0A000001, 1'b0, 4'h0, -1, 0, -1);
        run_instr(32'hE3510000, 1'b1, 4'b0000, -1, 0, -1);
        run_instr(32'h0A000001, 1'b0, 4'h0, -1, 0, -1);
        run_instr(32'hE5910004, 1'b0, 4'h0, 2, 3, -1);
        run_instr(32'hE5810004, 1'b0, 4'h0, -1, 0, 3);

        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 1) == 0) ins[31:28] = 4'hE;
            if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
            if ($urandom_range(0, 3) == 0) ins[24:21] = 4'b1010;
            s_at  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1;
            s_len = int'($urandom_range(1, 3));
            r_at  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(ins, 1'b0, 4'h0, s_at, s_len, r_at);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
